// File: rtl/bank_isu_dispatch.sv
// rtl/bank_isu_dispatch.sv - four-channel arbiter and ROB-id allocator feeding the bank issue queue
//
// Purpose:
//   Picks one of four channel requests per cycle, tags it with a free 3-bit
//   ROB id from an 8-entry pool and loads it into a single registered output
//   slot toward the issue-queue enqueue port (valid/allowIn handshake).
//   Retire logic returns ids through the release strobe.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   ch_valid_i / ch_ready_o          per-channel request handshake (ready is one-hot or zero)
//   ch_opcode_i, ch_set_way_offset_i,
//   ch_wbuffer_id_i, ch_cl_state_i   per-channel payload, channel n in slice n
//   req_valid_o / req_allowIn_i      output slot handshake
//   req_*_o                          registered request payload, granted channel and ROB id
//   rob_free_valid_i, rob_free_id_i  ROB id release strobe
//   rob_full_o                       all ROB ids busy
//
// Configuration:
//   BANK_ISU_DISPATCH_FIXED_PRIO_EN  defined: fixed priority (ch0 highest), no round-robin pointer.
//                                    undefined: round-robin starting after the last granted channel.

module bank_isu_dispatch #(
    parameter int NUM_CH    = 4,
    parameter int ROB_DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CH-1:0]      ch_valid_i,
    output logic [NUM_CH-1:0]      ch_ready_o,
    input  logic [7:0]             ch_opcode_i,
    input  logic [27:0]            ch_set_way_offset_i,
    input  logic [31:0]            ch_wbuffer_id_i,
    input  logic [15:0]            ch_cl_state_i,
    output logic                   req_valid_o,
    input  logic                   req_allowIn_i,
    output logic [2:0]             req_rob_id_o,
    output logic [1:0]             req_ch_id_o,
    output logic [1:0]             req_opcode_o,
    output logic [6:0]             req_set_way_offset_o,
    output logic [7:0]             req_wbuffer_id_o,
    output logic [1:0]             req_cacheline_offset0_state_o,
    output logic [1:0]             req_cacheline_offset1_state_o,
    input  logic                   rob_free_valid_i,
    input  logic [2:0]             rob_free_id_i,
    output logic                   rob_full_o
);

    logic [ROB_DEPTH-1:0] rob_busy_q, rob_busy_d;
    logic                 req_valid_q, req_valid_d;
    logic [2:0]           rob_id_q, rob_id_d;
    logic [1:0]           ch_id_q, ch_id_d;
    logic [1:0]           opcode_q, opcode_d;
    logic [6:0]           swo_q, swo_d;
    logic [7:0]           wbuf_q, wbuf_d;
    logic [1:0]           st0_q, st0_d;
    logic [1:0]           st1_q, st1_d;

    logic [1:0]           scan_base;
    logic [1:0]           cand;
    logic [1:0]           grant_idx;
    logic                 grant_found;
    logic [2:0]           alloc_id;
    logic                 rob_avail;
    logic                 load_en;
    logic                 fire;

`ifdef BANK_ISU_DISPATCH_FIXED_PRIO_EN
    assign scan_base = 2'd0;
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign scan_base = rr_ptr_q;
    // Pointer moves past the winner so the next scan starts at the following channel.
    assign rr_ptr_d  = fire ? grant_idx + 2'd1 : rr_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // First valid channel at or after scan_base, wrapping mod 4.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = scan_base + 2'(i);
            if (!grant_found && ch_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Lowest free ROB id: scan downward so the lowest clear bit wins last.
    always_comb begin
        alloc_id = 3'd0;
        for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
            if (!rob_busy_q[i]) begin
                alloc_id = 3'(i);
            end
        end
    end

    assign rob_avail = ~&rob_busy_q;
    assign load_en   = ~req_valid_q | req_allowIn_i;
    // Reset gates the handshake so no channel believes it was accepted while state is held clear.
    assign fire      = grant_found & load_en & rob_avail & ~rst_i;

    assign ch_ready_o = fire ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        req_valid_d = req_valid_q;
        rob_id_d    = rob_id_q;
        ch_id_d     = ch_id_q;
        opcode_d    = opcode_q;
        swo_d       = swo_q;
        wbuf_d      = wbuf_q;
        st0_d       = st0_q;
        st1_d       = st1_q;
        rob_busy_d  = rob_busy_q;

        // Release first, then allocate: the allocated id is clear, so a release
        // naming it is an idle release and must not undo the allocation.
        if (rob_free_valid_i) begin
            rob_busy_d[rob_free_id_i] = 1'b0;
        end

        if (fire) begin
            req_valid_d          = 1'b1;
            rob_id_d             = alloc_id;
            ch_id_d              = grant_idx;
            opcode_d             = ch_opcode_i[2*grant_idx +: 2];
            swo_d                = ch_set_way_offset_i[7*grant_idx +: 7];
            wbuf_d               = ch_wbuffer_id_i[8*grant_idx +: 8];
            st0_d                = ch_cl_state_i[4*grant_idx +: 2];
            st1_d                = ch_cl_state_i[4*grant_idx + 2 +: 2];
            rob_busy_d[alloc_id] = 1'b1;
        end else if (req_allowIn_i) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rob_busy_q  <= '0;
            req_valid_q <= 1'b0;
            rob_id_q    <= 3'd0;
            ch_id_q     <= 2'd0;
            opcode_q    <= 2'd0;
            swo_q       <= 7'd0;
            wbuf_q      <= 8'd0;
            st0_q       <= 2'd0;
            st1_q       <= 2'd0;
        end else begin
            rob_busy_q  <= rob_busy_d;
            req_valid_q <= req_valid_d;
            rob_id_q    <= rob_id_d;
            ch_id_q     <= ch_id_d;
            opcode_q    <= opcode_d;
            swo_q       <= swo_d;
            wbuf_q      <= wbuf_d;
            st0_q       <= st0_d;
            st1_q       <= st1_d;
        end
    end

    assign req_valid_o                   = req_valid_q;
    assign req_rob_id_o                  = rob_id_q;
    assign req_ch_id_o                   = ch_id_q;
    assign req_opcode_o                  = opcode_q;
    assign req_set_way_offset_o          = swo_q;
    assign req_wbuffer_id_o              = wbuf_q;
    assign req_cacheline_offset0_state_o = st0_q;
    assign req_cacheline_offset1_state_o = st1_q;
    assign rob_full_o                    = &rob_busy_q;

endmodule

// File: tb/tb_bank_isu_dispatch.sv
// tb/tb_bank_isu_dispatch.sv - scoreboard testbench for bank_isu_dispatch

module tb_bank_isu_dispatch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  ch_valid_i;
    logic [3:0]  ch_ready_o;
    logic [7:0]  ch_opcode_i;
    logic [27:0] ch_set_way_offset_i;
    logic [31:0] ch_wbuffer_id_i;
    logic [15:0] ch_cl_state_i;
    logic        req_valid_o;
    logic        req_allowIn_i;
    logic [2:0]  req_rob_id_o;
    logic [1:0]  req_ch_id_o;
    logic [1:0]  req_opcode_o;
    logic [6:0]  req_set_way_offset_o;
    logic [7:0]  req_wbuffer_id_o;
    logic [1:0]  req_cacheline_offset0_state_o;
    logic [1:0]  req_cacheline_offset1_state_o;
    logic        rob_free_valid_i;
    logic [2:0]  rob_free_id_i;
    logic        rob_full_o;

    bank_isu_dispatch dut (
        .clk_i                         (clk_i),
        .rst_i                         (rst_i),
        .ch_valid_i                    (ch_valid_i),
        .ch_ready_o                    (ch_ready_o),
        .ch_opcode_i                   (ch_opcode_i),
        .ch_set_way_offset_i           (ch_set_way_offset_i),
        .ch_wbuffer_id_i               (ch_wbuffer_id_i),
        .ch_cl_state_i                 (ch_cl_state_i),
        .req_valid_o                   (req_valid_o),
        .req_allowIn_i                 (req_allowIn_i),
        .req_rob_id_o                  (req_rob_id_o),
        .req_ch_id_o                   (req_ch_id_o),
        .req_opcode_o                  (req_opcode_o),
        .req_set_way_offset_o          (req_set_way_offset_o),
        .req_wbuffer_id_o              (req_wbuffer_id_o),
        .req_cacheline_offset0_state_o (req_cacheline_offset0_state_o),
        .req_cacheline_offset1_state_o (req_cacheline_offset1_state_o),
        .rob_free_valid_i              (rob_free_valid_i),
        .rob_free_id_i                 (rob_free_id_i),
        .rob_full_o                    (rob_full_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // {rob_id, ch_id, opcode, set_way_offset, wbuffer_id, st1, st0}
    logic [25:0] exp_q[$];

    logic [7:0] m_busy;
    logic [1:0] m_rr;
    logic       m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] observed();
        return {req_rob_id_o, req_ch_id_o, req_opcode_o, req_set_way_offset_o,
                req_wbuffer_id_o, req_cacheline_offset1_state_o, req_cacheline_offset0_state_o};
    endfunction

    task automatic new_payload(input int g);
        ch_opcode_i[2*g +: 2]         = 2'($urandom);
        ch_set_way_offset_i[7*g +: 7] = 7'($urandom);
        ch_wbuffer_id_i[8*g +: 8]     = 8'($urandom);
        ch_cl_state_i[4*g +: 4]       = 4'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_valid", 32'(req_valid_o), 32'd0);
        check("rst_full", 32'(rob_full_o), 32'd0);
        check("rst_ready", 32'(ch_ready_o), 32'd0);
        check("rst_payload", 32'(observed()), 32'd0);
        m_busy  = 8'h00;
        m_rr    = 2'd0;
        m_valid = 1'b0;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // One cycle: drive inputs, evaluate the reference model and compare at the
    // falling edge, then advance past the rising edge.
    task automatic step(input logic [3:0] v, input logic allow, input logic fv, input logic [2:0] fid);
        logic       load, avail, fire, found;
        logic [1:0] g, base, c;
        logic [2:0] alloc;
        logic [3:0] exp_ready;
        logic [25:0] item;
        ch_valid_i       = v;
        req_allowIn_i    = allow;
        rob_free_valid_i = fv;
        rob_free_id_i    = fid;
        @(negedge clk_i);
        load  = !m_valid || allow;
        avail = (m_busy != 8'hFF);
`ifdef BANK_ISU_DISPATCH_FIXED_PRIO_EN
        base = 2'd0;
`else
        base = m_rr;
`endif
        found = 1'b0;
        g     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            c = base + 2'(i);
            if (!found && v[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        alloc = 3'd0;
        for (int i = 7; i >= 0; i--) if (!m_busy[i]) alloc = 3'(i);
        fire      = found && load && avail;
        exp_ready = fire ? (4'b0001 << g) : 4'b0000;

        check("ch_ready", 32'(ch_ready_o), 32'(exp_ready));
        check("req_valid", 32'(req_valid_o), 32'(m_valid));
        check("rob_full", 32'(rob_full_o), 32'(m_busy == 8'hFF));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                check("req_payload", 32'(observed()), 32'(exp_q[0]));
                if (allow) void'(exp_q.pop_front());
            end
        end

        if (fv) m_busy[fid] = 1'b0;
        if (fire) begin
            item = {alloc, g, ch_opcode_i[2*g +: 2], ch_set_way_offset_i[7*g +: 7],
                    ch_wbuffer_id_i[8*g +: 8], ch_cl_state_i[4*g+2 +: 2], ch_cl_state_i[4*g +: 2]};
            exp_q.push_back(item);
            m_busy[alloc] = 1'b1;
            m_rr    = g + 2'd1;
            m_valid = 1'b1;
        end else if (allow) begin
            m_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
        if (fire) new_payload(int'(g));
    endtask

    initial begin
        rst_i               = 1'b1;
        ch_valid_i          = 4'b0000;
        req_allowIn_i       = 1'b0;
        rob_free_valid_i    = 1'b0;
        rob_free_id_i       = 3'd0;
        ch_opcode_i         = 8'($urandom);
        ch_set_way_offset_i = 28'($urandom);
        ch_wbuffer_id_i     = $urandom;
        ch_cl_state_i       = 16'($urandom);
        do_reset();

        // Single request from ch0 after reset.
        step(4'b0001, 1'b1, 1'b0, 3'd0);
        check("first_ch", 32'(req_ch_id_o), 32'd0);
        check("first_rob", 32'(req_rob_id_o), 32'd0);
        step(4'b0000, 1'b1, 1'b0, 3'd0);

        // Four back-to-back grants from a fresh pool.
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0, 3'd0);
        // Fill the pool to exhaustion, then stall, then release id 5.
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0, 3'd0);
        check("pool_full", 32'(rob_full_o), 32'd1);
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        step(4'b1111, 1'b1, 1'b1, 3'd5);
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        check("reuse_rob5", 32'(req_rob_id_o), 32'd5);

        // Free some ids, then hold backpressure for three cycles.
        step(4'b0000, 1'b1, 1'b1, 3'd1);
        step(4'b0000, 1'b1, 1'b1, 3'd2);
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 3'd0);
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        step(4'b0000, 1'b1, 1'b0, 3'd0);

        // Idle release of id 7 with ids 0..3 busy.
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0, 3'd0);
        step(4'b0000, 1'b1, 1'b1, 3'd7);
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        check("after_idle_rel", 32'(req_rob_id_o), 32'd4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 3'($urandom));
        end

        // Reset mid-stream with requests pending.
        do_reset();
        step(4'b1111, 1'b1, 1'b0, 3'd0);
        check("post_rst_ch", 32'(req_ch_id_o), 32'd0);
        check("post_rst_rob", 32'(req_rob_id_o), 32'd0);
        step(4'b0000, 1'b1, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
